// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with packet locking in front of a synchronous FIFO.
// Grants are combinational from registered state; a lock is held until last beat or BURST_MAX beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]    req_last_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic               fifo_full_i,
  output logic               fifo_wr_en_o,
  output logic [DW-1:0]      fifo_wdata_o,
  output logic               busy_o,
  output logic [2:0]         owner_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  int              idx_s;
  int              win_s;
  logic            win_ok_s;
  int              sel_s;
  logic            sel_ok_s;
  logic            sel_last_s;
  logic            xfer_s;
  logic            cap_s;
  int              nxt_s;

  // Round-robin search; descending offsets so the lowest offset from rr_ptr wins.
  always_comb begin
    idx_s    = 0;
    win_s    = 0;
    win_ok_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = int'(rr_ptr_q) + k;
      idx_s = (idx_s >= NREQ) ? (idx_s - NREQ) : idx_s;
      for (int i = 0; i < NREQ; i++) begin
        if ((i == idx_s) && req_valid_i[i]) begin
          win_s    = i;
          win_ok_s = 1'b1;
        end else begin
          win_s    = win_s;
          win_ok_s = win_ok_s;
        end
      end
    end
  end

  // Selection of the candidate requester and next-state computation.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    sel_ok_s   = 1'b0;
    sel_last_s = 1'b0;

    if (state_q == S_HOLD) begin
      sel_s = int'(owner_q);
    end else begin
      sel_s = win_s;
    end

    for (int i = 0; i < NREQ; i++) begin
      if (i == sel_s) begin
        sel_ok_s   = (state_q == S_HOLD) ? req_valid_i[i] : win_ok_s;
        sel_last_s = req_last_i[i];
      end else begin
        sel_ok_s   = sel_ok_s;
        sel_last_s = sel_last_s;
      end
    end

    xfer_s = sel_ok_s && !fifo_full_i && !rst;
    nxt_s  = ((sel_s + 1) >= NREQ) ? 0 : (sel_s + 1);
    cap_s  = (({1'b0, beat_cnt_q} + 9'd1) == 9'(BURST_MAX));

    case (state_q)
      S_IDLE: begin
        if (xfer_s) begin
          if (sel_last_s || (BURST_MAX == 1)) begin
            rr_ptr_d = PW'(nxt_s);
          end else begin
            state_d    = S_HOLD;
            owner_d    = 3'(sel_s);
            beat_cnt_d = 8'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (xfer_s) begin
          // Hitting the cap releases the port but not the packet; the requester re-arbitrates.
          if (sel_last_s || cap_s) begin
            state_d    = S_IDLE;
            rr_ptr_d   = PW'(nxt_s);
            owner_d    = 3'd0;
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d    = S_IDLE;
        owner_d    = 3'd0;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // Zero-latency datapath: ready, write strobe and data follow the selection directly.
  always_comb begin
    req_ready_o  = '0;
    fifo_wdata_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_s && (i == sel_s)) begin
        req_ready_o[i] = 1'b1;
        fifo_wdata_o   = req_data_i[i*DW +: DW];
      end else begin
        req_ready_o[i] = 1'b0;
      end
    end
    fifo_wr_en_o = xfer_s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= 3'd0;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy_o  = (state_q == S_HOLD);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// checked against a packet-level arbitration model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int BM   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    valid, last, ready;
  logic [NREQ*DW-1:0] data;
  logic               full, wr_en, busy;
  logic [DW-1:0]      wdata;
  logic [2:0]         owner;

  int vectors = 0;
  int errors  = 0;
  int m_lock  = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .fifo_full_i(full), .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata),
    .busy_o(busy), .owner_o(owner)
  );

  // Who may write this cycle, from the arbitration rules.
  function automatic int model_grant();
    if (rst || full) return -1;
    if (m_lock >= 0) return valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance the model by the transfer g (or none), then move past the clock edge.
  task automatic adv(input int g);
    if (rst) begin
      m_lock = -1; m_ptr = 0; m_cnt = 0;
    end else if (g >= 0) begin
      if (m_lock < 0) begin
        if (last[g] || BM == 1) m_ptr = (g + 1) % NREQ;
        else begin m_lock = g; m_cnt = 1; end
      end else if (last[g] || m_cnt + 1 == BM) begin
        m_lock = -1; m_cnt = 0; m_ptr = (g + 1) % NREQ;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    valid[i] = v;
    last[i]  = l;
    data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '1; last = '1; full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (ready !== '0 || wr_en !== 1'b0 || wdata !== '0 || busy !== 1'b0 || owner !== 3'd0) begin
        errors++;
        $display("FAIL reset: ready=%b wr_en=%b wdata=%h busy=%b owner=%0d, want all zero",
                 ready, wr_en, wdata, busy, owner);
      end
      adv(model_grant());
    end
    rst = 1'b0; valid = '0; last = '0;
  endtask

  task automatic test_rotation();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, DW'(16'hA000 + i));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (ready !== onehot(exp_g[c]) || wr_en !== 1'b1 || wdata !== DW'(16'hA000 + exp_g[c])) begin
        errors++;
        $display("FAIL rotation[%0d]: ready=%b wr_en=%b wdata=%h, want ready=%b wr_en=1 wdata=%h",
                 c, ready, wr_en, wdata, onehot(exp_g[c]), DW'(16'hA000 + exp_g[c]));
      end
      adv(model_grant());
    end
    valid = '0; last = '0;
  endtask

  task automatic test_lock();
    int   exp_g[4] = '{1, 1, 1, 2};
    logic exp_b[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] exp_d[4] = '{16'hB101, 16'hB102, 16'hB103, 16'hC200};
    set_req(1, 1'b1, 1'b0, 16'hB101);
    set_req(2, 1'b1, 1'b1, 16'hC200);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (ready !== onehot(exp_g[c]) || wdata !== exp_d[c] || busy !== exp_b[c] ||
          (exp_b[c] && owner !== 3'd1)) begin
        errors++;
        $display("FAIL lock[%0d]: ready=%b wdata=%h busy=%b owner=%0d, want ready=%b wdata=%h busy=%b owner=1",
                 c, ready, wdata, busy, owner, onehot(exp_g[c]), exp_d[c], exp_b[c]);
      end
      adv(model_grant());
      if (c < 2) set_req(1, 1'b1, (c == 1), exp_d[c+1]);
      else valid[1] = 1'b0;
    end
    valid = '0; last = '0;
  endtask

  task automatic test_burst_cap();
    int   exp_g[7] = '{0, 0, 0, 0, 3, 0, 0};
    logic exp_b[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int   b = 1;
    logic [DW-1:0] ed;
    set_req(0, 1'b1, 1'b0, DW'(16'h0B00 + b));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ed = (exp_g[c] == 0) ? DW'(16'h0B00 + b) : 16'h3333;
      vectors++;
      if (ready !== onehot(exp_g[c]) || wdata !== ed || busy !== exp_b[c]) begin
        errors++;
        $display("FAIL burst_cap[%0d]: ready=%b wdata=%h busy=%b, want ready=%b wdata=%h busy=%b",
                 c, ready, wdata, busy, onehot(exp_g[c]), ed, exp_b[c]);
      end
      adv(model_grant());
      if (c == 0) set_req(3, 1'b1, 1'b1, 16'h3333);
      if (exp_g[c] == 3) valid[3] = 1'b0;
      if (exp_g[c] == 0) begin
        b++;
        if (b > 6) valid[0] = 1'b0;
        else set_req(0, 1'b1, (b == 6), DW'(16'h0B00 + b));
      end
    end
    valid = '0; last = '0;
  endtask

  task automatic test_full();
    int   exp_g[7] = '{2, -1, -1, -1, 2, 2, 1};
    logic exp_b[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   b = 1;
    set_req(2, 1'b1, 1'b0, DW'(16'hD200 + b));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vectors++;
      if (ready !== onehot(exp_g[c]) || wr_en !== (exp_g[c] >= 0) || busy !== exp_b[c] ||
          (exp_b[c] && owner !== 3'd2)) begin
        errors++;
        $display("FAIL full[%0d]: ready=%b wr_en=%b busy=%b owner=%0d, want ready=%b busy=%b owner=2",
                 c, ready, wr_en, busy, owner, onehot(exp_g[c]), exp_b[c]);
      end
      adv(model_grant());
      if (c == 0) begin full = 1'b1; set_req(1, 1'b1, 1'b1, 16'hE100); end
      if (c == 3) full = 1'b0;
      if (exp_g[c] == 1) valid[1] = 1'b0;
      if (exp_g[c] == 2) begin
        b++;
        if (b > 3) valid[2] = 1'b0;
        else set_req(2, 1'b1, (b == 3), DW'(16'hD200 + b));
      end
    end
    valid = '0; last = '0;
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b1, 1'b0, 16'hF201);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (ready !== 4'b0100 || busy !== (c == 1)) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d]: ready=%b busy=%b, want ready=0100 busy=%b", c, ready, busy, (c == 1));
      end
      adv(model_grant());
      data[2*DW +: DW] = 16'hF202;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== '0 || wr_en !== 1'b0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_force: ready=%b wr_en=%b wdata=%h, want 0 0 0", ready, wr_en, wdata);
    end
    adv(model_grant());
    rst = 1'b0;
    set_req(1, 1'b1, 1'b1, 16'h1111);
    set_req(2, 1'b1, 1'b1, 16'h2222);
    set_req(3, 1'b1, 1'b1, 16'h3333);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || owner !== 3'd0 || ready !== 4'b0010 || wdata !== 16'h1111) begin
      errors++;
      $display("FAIL reset_mid_post: busy=%b owner=%0d ready=%b wdata=%h, want 0 0 0010 1111",
               busy, owner, ready, wdata);
    end
    adv(model_grant());
    valid = '0; last = '0;
  endtask

  task automatic test_random();
    int rem[NREQ];
    int g;
    logic [NREQ-1:0] er;
    logic [DW-1:0]   ed;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom % 100 == 0);
      full = ($urandom % 4 == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!valid[i] && ($urandom % 2 == 1)) begin
          if (rem[i] == 0) rem[i] = 1 + $urandom % 7;
          set_req(i, 1'b1, (rem[i] == 1), DW'($urandom));
        end
      end
      @(negedge clk);
      g  = model_grant();
      er = onehot(g);
      ed = (g >= 0) ? data[g*DW +: DW] : '0;
      vectors++;
      if (ready !== er || wr_en !== (g >= 0) || wdata !== ed || busy !== (m_lock >= 0) ||
          owner !== ((m_lock >= 0) ? 3'(m_lock) : 3'd0)) begin
        errors++;
        $display("FAIL random[%0d]: ready=%b wr_en=%b wdata=%h busy=%b owner=%0d, want %b %b %h %b %0d",
                 n, ready, wr_en, wdata, busy, owner, er, (g >= 0), ed, (m_lock >= 0),
                 (m_lock >= 0) ? m_lock : 0);
      end
      adv(g);
      if (g >= 0) begin rem[g]--; valid[g] = 1'b0; end
      if (rst) begin
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        valid = '0;
      end
    end
    rst = 1'b0; full = 1'b0; valid = '0;
  endtask

  initial begin
    rst = 1'b1; valid = '0; last = '0; data = '0; full = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_lock();
    test_burst_cap();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
